spi_flash_responder: RTL and testbench

- SPI flash-device model: the slave/responder end of the XIP flash path driven by the APB SPI master bridge.
- Decodes the serial READ (0x03) command plus a 24-bit address from the SPI bus.
- Fetches words from a synchronous 1-cycle-latency memory port and streams bytes back on MISO.
- Sits beside the SPI master in the SoC simulation top; all logic runs in the system clock domain, with the SPI pins oversampled.

---
 rtl/spi_flash_pkg.sv | 30 +++
 rtl/spi_flash_responder_pin_sync.sv | 46 ++++
 rtl/spi_flash_responder.sv | 216 +++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states,
// bit-counter widths and the byte-lane selector used by the data path.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    // One counter serves opcode (8), address (24), dummy (8) and data (8) bits.
    localparam int BIT_CNT_W = 5;
    localparam logic [BIT_CNT_W-1:0] OP_LAST_BIT    = 5'd7;
    localparam logic [BIT_CNT_W-1:0] ADDR_LAST_BIT  = 5'd23;
    localparam logic [BIT_CNT_W-1:0] DUMMY_LAST_BIT = 5'd7;
    localparam logic [BIT_CNT_W-1:0] BYTE_LAST_BIT  = 5'd7;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        FETCH,
        DATA,
        IGNORE
    } state_t;

    // Little-endian lane select: lane k holds byte address 4n+k.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/spi_flash_responder_pin_sync.sv
// Pin synchronizer for the SPI responder: sck, ss and mosi each pass through
// SYNC_STAGES flops; sck and ss keep one extra flop so edges are detected
// from the last two synced samples. mosi is delayed by the same depth as sck,
// so mosi_s is aligned with sck_rise.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic mosi_s
);

    logic [SYNC_STAGES:0]   sck_pipe;
    logic [SYNC_STAGES:0]   ss_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;

    // Shift each pin into its synchronizer chain; cleared chains mean a held-low
    // ss at reset release is not mistaken for a new select.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sck_pipe  <= '0;
            ss_pipe   <= '0;
            mosi_pipe <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop in the chain sampling
            // the value from before this edge, which is what makes it a shift chain.
            sck_pipe  <= {sck_pipe[SYNC_STAGES-1:0], sck};
            ss_pipe   <= {ss_pipe[SYNC_STAGES-1:0], ss};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
        end
    end

    assign sck_rise = sck_pipe[SYNC_STAGES-1] & ~sck_pipe[SYNC_STAGES];
    assign sck_fall = ~sck_pipe[SYNC_STAGES-1] & sck_pipe[SYNC_STAGES];
    assign ss_fall  = ~ss_pipe[SYNC_STAGES-1] & ss_pipe[SYNC_STAGES];
    assign ss_rise  = ss_pipe[SYNC_STAGES-1] & ~ss_pipe[SYNC_STAGES];
    assign mosi_s   = mosi_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash responder (mode 0): decodes READ 0x03 + 24-bit address, fetches
// 32-bit words from a 1-cycle-latency memory and streams bytes on MISO,
// prefetching the next word during the last byte of the current one.
// Optional build macro FAST_READ_EN also accepts 0x0B with 8 dummy cycles.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_ren,
    output logic [ADDR_W-3:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              err_cmd
);

    logic sck_rise, sck_fall, ss_fall, ss_rise, mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clock    (clock),
        .reset    (reset),
        .sck      (spi_sck),
        .ss       (spi_ss),
        .mosi     (spi_mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_fall  (ss_fall),
        .ss_rise  (ss_rise),
        .mosi_s   (mosi_s)
    );

    state_t                state, state_n;
    logic [BIT_CNT_W-1:0]  bitcnt, bitcnt_n;
    logic [7:0]            opcode, opcode_n;
    logic [ADDR_W-1:0]     addr, addr_n;
    logic [7:0]            shreg, shreg_n;
    logic [31:0]           wordbuf, wordbuf_n;
    logic [31:0]           nextbuf, nextbuf_n;
    logic                  rd_valid;
    logic                  miso_n, ren_n, err_n;
    logic [ADDR_W-3:0]     raddr_n;

    assign busy = (state != IDLE);

    // State and data-path registers; reset aborts any transfer in progress.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            bitcnt    <= '0;
            opcode    <= '0;
            addr      <= '0;
            shreg     <= '0;
            wordbuf   <= '0;
            nextbuf   <= '0;
            rd_valid  <= 1'b0;
            spi_miso  <= 1'b0;
            mem_ren   <= 1'b0;
            mem_raddr <= '0;
            err_cmd   <= 1'b0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            opcode    <= opcode_n;
            addr      <= addr_n;
            shreg     <= shreg_n;
            wordbuf   <= wordbuf_n;
            nextbuf   <= nextbuf_n;
            // Read data returns one cycle after the strobe; drop it if ss just rose.
            rd_valid  <= mem_ren & ~ss_rise;
            spi_miso  <= miso_n;
            mem_ren   <= ren_n;
            mem_raddr <= raddr_n;
            err_cmd   <= err_n;
        end
    end

    // Next-state and next-output decode; ss deassertion overrides any sck edge.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_n   = state;
        bitcnt_n  = bitcnt;
        opcode_n  = opcode;
        addr_n    = addr;
        shreg_n   = shreg;
        wordbuf_n = wordbuf;
        nextbuf_n = nextbuf;
        miso_n    = spi_miso;
        ren_n     = 1'b0;
        raddr_n   = mem_raddr;
        err_n     = 1'b0;

        if (ss_rise) begin
            state_n  = IDLE;
            bitcnt_n = '0;
            miso_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    miso_n = 1'b0;
                    if (ss_fall) begin
                        state_n  = CMD;
                        bitcnt_n = '0;
                        opcode_n = '0;
                    end
                end
                CMD: begin
                    miso_n = 1'b0;
                    if (sck_rise) begin
                        opcode_n = {opcode[6:0], mosi_s};
                        bitcnt_n = bitcnt + BIT_CNT_W'(1);
                        if (bitcnt == OP_LAST_BIT) begin
                            bitcnt_n = '0;
                            addr_n   = '0;
                            if (opcode_n == OP_READ) begin
                                state_n = ADDR;
`ifdef FAST_READ_EN
                            end else if (opcode_n == OP_FAST_READ) begin
                                state_n = ADDR;
`endif
                            end else begin
                                state_n = IGNORE;
                                err_n   = 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    miso_n = 1'b0;
                    if (sck_rise) begin
                        addr_n   = {addr[ADDR_W-2:0], mosi_s};
                        bitcnt_n = bitcnt + BIT_CNT_W'(1);
                        if (bitcnt == ADDR_LAST_BIT) begin
                            bitcnt_n = '0;
`ifdef FAST_READ_EN
                            if (opcode == OP_FAST_READ) begin
                                state_n = DUMMY;
                            end else begin
                                state_n = FETCH;
                                ren_n   = 1'b1;
                                raddr_n = addr_n[ADDR_W-1:2];
                            end
`else
                            state_n = FETCH;
                            ren_n   = 1'b1;
                            raddr_n = addr_n[ADDR_W-1:2];
`endif
                        end
                    end
                end
                DUMMY: begin
                    miso_n = 1'b0;
                    if (sck_rise) begin
                        bitcnt_n = bitcnt + BIT_CNT_W'(1);
                        if (bitcnt == DUMMY_LAST_BIT) begin
                            bitcnt_n = '0;
                            state_n  = FETCH;
                            ren_n    = 1'b1;
                            raddr_n  = addr[ADDR_W-1:2];
                        end
                    end
                end
                FETCH: begin
                    if (rd_valid) begin
                        wordbuf_n = mem_rdata;
                        shreg_n   = byte_lane(mem_rdata, addr[1:0]);
                        bitcnt_n  = '0;
                        state_n   = DATA;
                    end
                end
                DATA: begin
                    if (rd_valid) begin
                        nextbuf_n = mem_rdata;
                    end
                    if (sck_fall) begin
                        miso_n  = shreg[7];
                        shreg_n = {shreg[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        // Prefetch the following word as the last byte of this one starts.
                        if (bitcnt == '0 && addr[1:0] == 2'b11) begin
                            ren_n   = 1'b1;
                            raddr_n = addr[ADDR_W-1:2] + (ADDR_W-2)'(1);
                        end
                        bitcnt_n = bitcnt + BIT_CNT_W'(1);
                        if (bitcnt == BYTE_LAST_BIT) begin
                            bitcnt_n = '0;
                            addr_n   = addr + ADDR_W'(1);
                            if (addr_n[1:0] == 2'b00) begin
                                wordbuf_n = nextbuf;
                                shreg_n   = byte_lane(nextbuf, 2'b00);
                            end else begin
                                shreg_n   = byte_lane(wordbuf, addr_n[1:0]);
                            end
                        end
                    end
                end
                IGNORE: begin
                    miso_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    miso_n  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: plays an SPI mode-0 master with a
// 12-clock sck period (divider 3) against a small word memory model.
module tb_spi_flash_responder;

    localparam int ADDR_W = 24;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              spi_sck = 1'b0;
    logic              spi_ss = 1'b1;
    logic              spi_mosi = 1'b0;
    logic              spi_miso;
    logic              mem_ren;
    logic [ADDR_W-3:0] mem_raddr;
    logic [31:0]       mem_rdata = '0;
    logic              busy;
    logic              err_cmd;

    int n_tests = 0;
    int n_fail  = 0;

    int                cyc = 0;
    int                ren_cnt = 0;
    int                err_cnt = 0;
    bit                miso_hi = 1'b0;
    logic [ADDR_W-3:0] ren_addr[$];
    int                ren_cyc[$];

    spi_flash_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err_cmd   (err_cmd)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-3:0] waddr);
        case (waddr)
            22'h000000: return 32'h0000_00BB;
            22'h000001: return 32'h4433_2211;
            22'h000002: return 32'h8877_6655;
            22'h3FFFFF: return 32'hAA00_0000;
            default:    return 32'h0000_0000;
        endcase
    endfunction

    // Synchronous memory: data valid the cycle after the strobe.
    always @(posedge clock) begin
        if (mem_ren) mem_rdata <= mem_word(mem_raddr);
    end

    // Event monitor, sampled away from the active edge.
    always @(negedge clock) begin
        cyc++;
        if (mem_ren) begin
            ren_cnt++;
            ren_addr.push_back(mem_raddr);
            ren_cyc.push_back(cyc);
        end
        if (err_cmd) err_cnt++;
        if (spi_miso) miso_hi = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One mode-0 bit: mosi set while sck low, miso sampled as sck rises.
    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        repeat (6) @(negedge clock);
        spi_sck = 1'b1;
        r = spi_miso;
        repeat (6) @(negedge clock);
        spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic start_cmd(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] junk;
        spi_ss = 1'b0;
        spi_byte(op, junk);
        spi_byte(a[23:16], junk);
        spi_byte(a[15:8], junk);
        spi_byte(a[7:0], junk);
    endtask

    task automatic end_xfer();
        repeat (4) @(negedge clock);
        spi_ss = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx;
        logic       b;
        int         t_fall;
        int         e0, r0, hits;

        // Reset with ss held asserted.
        reset  = 1'b0;
        spi_ss = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_miso", spi_miso, 0);
        check("rst_ren", mem_ren, 0);
        check("rst_raddr", mem_raddr, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_cmd, 0);
        reset = 1'b1;
        // ss never seen deasserted since reset: sck activity must be ignored.
        spi_bit(1'b0, b);
        spi_bit(1'b0, b);
        check("hold_idle_busy", busy, 0);
        end_xfer();

        // READ @0x000004, four bytes from word 1.
        ren_addr.delete();
        ren_cyc.delete();
        start_cmd(8'h03, 24'h000004);
        check("rd4_busy", busy, 1);
        spi_byte(8'h00, rx); check("rd4_b0", rx, 8'h11);
        spi_byte(8'h00, rx); check("rd4_b1", rx, 8'h22);
        spi_byte(8'h00, rx); check("rd4_b2", rx, 8'h33);
        spi_byte(8'h00, rx); check("rd4_b3", rx, 8'h44);
        end_xfer();
        check("rd4_first_raddr", (ren_addr.size() > 0) ? ren_addr[0] : 22'h3FFFFF, 1);
        hits = 0;
        foreach (ren_addr[i]) if (ren_addr[i] == 22'd1) hits++;
        check("rd4_word1_fetches", hits, 1);
        check("rd4_busy_after", busy, 0);

        // READ @0x000006 crossing into word 2, prefetch timing.
        ren_addr.delete();
        ren_cyc.delete();
        start_cmd(8'h03, 24'h000006);
        spi_byte(8'h00, rx); check("rd6_b0", rx, 8'h33);
        spi_byte(8'h00, rx); check("rd6_b1", rx, 8'h44);
        t_fall = cyc;
        spi_byte(8'h00, rx); check("rd6_b2", rx, 8'h55);
        spi_byte(8'h00, rx); check("rd6_b3", rx, 8'h66);
        end_xfer();
        check("rd6_ren_count_ge2", ren_addr.size() >= 2, 1);
        if (ren_addr.size() >= 2) begin
            check("rd6_prefetch_raddr", ren_addr[1], 2);
            check("rd6_prefetch_early", ren_cyc[1] < t_fall, 1);
        end

        // READ @0xFFFFFF wraps to address 0.
        start_cmd(8'h03, 24'hFFFFFF);
        spi_byte(8'h00, rx); check("wrap_b0", rx, 8'hAA);
        spi_byte(8'h00, rx); check("wrap_b1", rx, 8'hBB);
        end_xfer();

        // Unsupported opcode 0x9F.
        e0 = err_cnt;
        r0 = ren_cnt;
        spi_ss = 1'b0;
        repeat (2) @(negedge clock);
        miso_hi = 1'b0;
        spi_byte(8'h9F, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        check("bad_op_err_pulses", err_cnt - e0, 1);
        check("bad_op_miso_high", miso_hi, 0);
        check("bad_op_ren", ren_cnt - r0, 0);
        end_xfer();

        // Abort after 12 address bits, then a fresh READ @0.
        spi_ss = 1'b0;
        spi_byte(8'h03, rx);
        for (int i = 0; i < 12; i++) spi_bit(1'b1, b);
        end_xfer();
        check("abort_busy", busy, 0);
        start_cmd(8'h03, 24'h000000);
        spi_byte(8'h00, rx); check("abort_fresh_b0", rx, 8'hBB);
        end_xfer();

        // Reset mid-DATA.
        start_cmd(8'h03, 24'hFFFFFF);
        spi_bit(1'b0, b);
        check("mid_rst_first_bit", b, 1);
        check("mid_rst_miso_pre", spi_miso, 1);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_miso", spi_miso, 0);
        check("mid_rst_ren", mem_ren, 0);
        check("mid_rst_raddr", mem_raddr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err_cmd, 0);
        spi_ss = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (8) @(negedge clock);

        // FAST_READ 0x0B @0x000004.
        ren_addr.delete();
        ren_cyc.delete();
        e0 = err_cnt;
        r0 = ren_cnt;
`ifdef FAST_READ_EN
        start_cmd(8'h0B, 24'h000004);
        miso_hi = 1'b0;
        spi_byte(8'h00, rx);
        check("fast_dummy_miso", miso_hi, 0);
        spi_byte(8'h00, rx); check("fast_b0", rx, 8'h11);
        check("fast_raddr", (ren_addr.size() > 0) ? ren_addr[0] : 22'h3FFFFF, 1);
        check("fast_err", err_cnt - e0, 0);
`else
        start_cmd(8'h0B, 24'h000004);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        check("fast_off_err", err_cnt - e0, 1);
        check("fast_off_ren", ren_cnt - r0, 0);
        check("fast_off_miso", rx, 8'h00);
`endif
        end_xfer();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
